// File: rtl/spi_copi_receiver.sv
// SPI write-path receiver: oversamples SCK/CS/COPI on the system clock, decodes a 16-bit
// start address then data bytes, and emits one memory write strobe per data byte.
module spi_copi_receiver #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sck,
  input  logic        cs,
  input  logic        copi,
  output logic [7:0]  mem_write_data,
  output logic [15:0] mem_write_address,
  output logic        mem_write_enable,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] bytes_written
);

  typedef enum logic [1:0] {StIdle, StAddrHi, StAddrLo, StData} state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, copi_sync_q;
  logic                   sck_dly_q, cs_dly_q;
  logic                   sck_s, cs_s, copi_s;
  logic                   sck_rise, cs_rise, cs_fall, bit_done;
  logic [2:0]             bit_cnt_q;
  logic [7:0]             shift_q, byte_next;
  logic [15:0]            addr_q;
  logic [7:0]             wdata_q;
  logic [15:0]            waddr_q;
  logic                   we_q;
  logic [15:0]            bw_q;

  assign sck_s     = sck_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign copi_s    = copi_sync_q[SYNC_STAGES-1];
  assign sck_rise  = sck_s & ~sck_dly_q;
  assign cs_rise   = cs_s & ~cs_dly_q;
  assign cs_fall   = ~cs_s & cs_dly_q;
  assign byte_next = {shift_q[6:0], copi_s};
  assign bit_done  = sck_rise & cs_s & (bit_cnt_q == 3'd7);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '0;
      copi_sync_q <= '0;
      sck_dly_q   <= 1'b0;
      cs_dly_q    <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
      copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
      sck_dly_q   <= sck_s;
      cs_dly_q    <= cs_s;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // CS fall wins over everything so a partial byte can never complete a transition.
  always_comb begin
    state_d = state_q;
    if (cs_fall) begin
      state_d = StIdle;
    end else if (cs_rise) begin
      state_d = StAddrHi;
    end else if (bit_done) begin
      unique case (state_q)
        StAddrHi: state_d = StAddrLo;
        StAddrLo: state_d = StData;
        default:  state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      bit_cnt_q <= '0;
      shift_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      waddr_q   <= '0;
      we_q      <= 1'b0;
      bw_q      <= '0;
    end else begin
      we_q <= 1'b0;
      if (cs_fall) begin
        bit_cnt_q <= '0;
      end else if (cs_rise) begin
        bit_cnt_q <= '0;
        shift_q   <= '0;
        bw_q      <= '0;
      end else if (sck_rise && cs_s) begin
        shift_q   <= byte_next;
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          case (state_q)
            StAddrHi: addr_q[15:8] <= byte_next;
            StAddrLo: addr_q[7:0]  <= byte_next;
            StData: begin
              we_q    <= 1'b1;
              wdata_q <= byte_next;
              waddr_q <= addr_q;
              addr_q  <= addr_q + 16'd1;
              if (bw_q != 16'hFFFF) begin
                bw_q <= bw_q + 16'd1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign mem_write_data    = wdata_q;
  assign mem_write_address = waddr_q;
  assign mem_write_enable  = we_q;
  assign busy              = cs_s;
  assign frame_done        = cs_fall;
  assign bytes_written     = bw_q;

endmodule

// File: tb/tb_spi_copi_receiver.sv
// Directed bench for spi_copi_receiver: frame-level model of expected writes, checked by a
// single compare process on every strobe, plus per-frame status checks.
module tb_spi_copi_receiver;

  localparam int unsigned SyncStages = 2;
  // Pin rise of the 8th bit to strobe-sample cycle: 2 sync stages, edge cycle, strobe register.
  localparam int StrobeLat = 3;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        sck = 1'b0;
  logic        cs = 1'b0;
  logic        copi = 1'b0;
  logic [7:0]  mem_write_data;
  logic [15:0] mem_write_address;
  logic        mem_write_enable;
  logic        busy;
  logic        frame_done;
  logic [15:0] bytes_written;

  spi_copi_receiver #(.SYNC_STAGES(SyncStages)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .sck              (sck),
    .cs               (cs),
    .copi             (copi),
    .mem_write_data   (mem_write_data),
    .mem_write_address(mem_write_address),
    .mem_write_enable (mem_write_enable),
    .busy             (busy),
    .frame_done       (frame_done),
    .bytes_written    (bytes_written)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          last_rise = 0;
  int          fd_count = 0;
  logic        prev_busy = 1'b0;
  logic [7:0]  tx_q[$];
  logic [23:0] exp_q[$];
  logic [15:0] exp_bw;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [23:0] e;
    if (resetn) begin
      if (mem_write_enable) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_strobe: got addr %0h data %0h, expected no write",
                   mem_write_address, mem_write_data);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 32'(mem_write_address), 32'(e[23:8]));
          check("wr_data", 32'(mem_write_data), 32'(e[7:0]));
          check("strobe_latency", 32'(cyc - last_rise), 32'(StrobeLat));
        end
      end
      if (frame_done) begin
        fd_count++;
        check("frame_done_vs_busy", {30'd0, busy, prev_busy}, 32'b01);
      end
      prev_busy = busy;
    end else begin
      prev_busy = 1'b0;
    end
  end

  // Frame-level model: first two bytes are the address, the rest are written sequentially.
  task automatic model_frame();
    logic [15:0] a;
    int n;
    n = tx_q.size();
    exp_bw = (n >= 2) ? 16'(n - 2) : 16'd0;
    if (n >= 3) begin
      a = {tx_q[0], tx_q[1]};
      for (int i = 2; i < n; i++) begin
        exp_q.push_back({a, tx_q[i]});
        a = a + 16'd1;
      end
    end
  endtask

  task automatic send_bit(input logic b);
    copi = b;
    sck  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sck = 1'b1;
    last_rise = cyc;
    repeat (2) @(posedge clk);
    #1;
    sck = 1'b0;
  endtask

  task automatic send_payload(input int extra_bits, input logic [7:0] extra_val);
    for (int i = 0; i < tx_q.size(); i++) begin
      for (int b = 7; b >= 0; b--) send_bit(tx_q[i][b]);
    end
    for (int b = 0; b < extra_bits; b++) send_bit(extra_val[7-b]);
  endtask

  task automatic send_frame(input int extra_bits, input logic [7:0] extra_val);
    int fd0;
    fd0 = fd_count;
    @(posedge clk);
    #1;
    cs = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("busy_in_frame", 32'(busy), 32'd1);
    send_payload(extra_bits, extra_val);
    repeat (3) @(posedge clk);
    #1;
    cs = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("busy_after_frame", 32'(busy), 32'd0);
    check("bytes_written", 32'(bytes_written), 32'(exp_bw));
    check("strobes_outstanding", 32'(exp_q.size()), 32'd0);
    check("frame_done_pulses", 32'(fd_count - fd0), 32'd1);
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"}, 32'(mem_write_data), 32'd0);
    check({tag, "_addr"}, 32'(mem_write_address), 32'd0);
    check({tag, "_we"}, 32'(mem_write_enable), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check({tag, "_bytes_written"}, 32'(bytes_written), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1;
    resetn = 1'b1;
    repeat (3) @(posedge clk);

    // Basic frame, with hand-computed pins on the model.
    tx_q = '{8'h01, 8'h20, 8'hAA, 8'h55, 8'h0F};
    model_frame();
    check("model_pin_first", 32'(exp_q[0]), 32'h0120AA);
    check("model_pin_last", 32'(exp_q[2]), 32'h01220F);
    check("model_pin_bw", 32'(exp_bw), 32'd3);
    send_frame(0, 8'h00);

    // Address wrap.
    tx_q = '{8'hFF, 8'hFF, 8'h11, 8'h22};
    model_frame();
    check("model_pin_wrap", 32'(exp_q[1]), 32'h000022);
    send_frame(0, 8'h00);

    // Trailing partial byte discarded.
    tx_q = '{8'h00, 8'h10, 8'hC3};
    model_frame();
    send_frame(5, 8'hA8);

    // Incomplete address: no writes, then a clean frame.
    tx_q = '{8'h12};
    model_frame();
    check("model_pin_short", 32'(exp_q.size()), 32'd0);
    send_frame(4, 8'h50);
    tx_q = '{8'h30, 8'h00, 8'h99, 8'h66};
    model_frame();
    send_frame(0, 8'h00);

    // Reset during the second data byte.
    tx_q = '{8'h00, 8'h40, 8'h11};
    model_frame();
    @(posedge clk);
    #1;
    cs = 1'b1;
    repeat (5) @(posedge clk);
    send_payload(4, 8'h20);
    @(posedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(negedge clk);
    check_all_zero("midreset");
    repeat (4) @(posedge clk);
    #1;
    cs = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("midreset_strobes", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    tx_q = '{8'h00, 8'h05, 8'h7E};
    model_frame();
    check("model_pin_after_reset", 32'(exp_q[0]), 32'h00057E);
    send_frame(0, 8'h00);

    // Long random frame at clk/4.
    tx_q.delete();
    for (int i = 0; i < 66; i++) tx_q.push_back(8'($urandom));
    model_frame();
    send_frame(0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_copi_receiver.md
# spi_copi_receiver

Receives SPI write transactions from the nRF on the COPI line and writes the payload bytes into local FPGA memory. It is the write-direction counterpart of the SPI read path, which streams memory out on CIPO. The block runs on the FPGA system clock: it oversamples SCK, CS and COPI through synchronizers, decodes a 16-bit start address followed by data bytes, and emits one memory write strobe per received data byte with an auto-incrementing address.

## Interface
- SYNC_STAGES, 2: synchronizer depth for sck, cs, copi (minimum 2).
- clk  input  1  system clock; must be at least 4x the SCK frequency.
- resetn  input  1  synchronous, active-low reset.
- sck  input  1  SPI clock from nRF, asynchronous to clk, mode 0 (idle low, sample on rising edge).
- cs  input  1  SPI chip select, active high, asynchronous to clk.
- copi  input  1  SPI data from nRF, MSB first.
- mem_write_data  output  8  byte to write; valid while mem_write_enable is high.
- mem_write_address  output  16  target address; valid while mem_write_enable is high.
- mem_write_enable  output  1  single-cycle write strobe.
- busy  output  1  high while a transaction is in progress (synchronized cs high).
- frame_done  output  1  single-cycle pulse when synchronized cs falls.
- bytes_written  output  16  data bytes written in the current or most recent frame; cleared at frame start.

## Operation
- sck, cs, copi each pass through SYNC_STAGES flops; the last stage plus one delay flop per signal gives rising/falling edge detect for sck and cs.
- Frame start: synchronized cs rising edge. Clears bit counter, shift register, bytes_written; enters ADDR_HI.
- On each synchronized sck rising edge with cs high: shift register <= {shift[6:0], copi_sync}; bit counter increments modulo 8.
- On the 8th bit, byte completes; action depends on state:
  - ADDR_HI: address[15:8] <= byte; go ADDR_LO.
  - ADDR_LO: address[7:0] <= byte; go DATA.
  - DATA: present byte on mem_write_data, current address on mem_write_address, pulse mem_write_enable; then address <= address + 1 (16-bit wrap, 0xFFFF -> 0x0000); bytes_written <= bytes_written + 1 (saturates at 0xFFFF).
- States: IDLE, ADDR_HI, ADDR_LO, DATA. IDLE -> ADDR_HI on cs rise; any state -> IDLE on cs fall.
- cs fall in any state: partial byte discarded (no write), bit counter cleared, frame_done pulses, bytes_written holds its value until next frame start.
- Frame with fewer than 3 complete bytes produces no writes.
- cs rise and fall in the same cycle cannot occur after synchronization; sck edges while cs low are ignored.
- resetn low: state IDLE, all counters, shift register and address zero; takes priority over everything.

## Timing
- Reset values: mem_write_data 0, mem_write_address 0, mem_write_enable 0, busy 0, frame_done 0, bytes_written 0.
- Input-to-detect latency: SYNC_STAGES + 1 clk cycles from pin edge to internal edge pulse.
- mem_write_enable asserts exactly one cycle after the edge-detect cycle of the 8th bit of a data byte, for exactly one cycle; data/address stable in that cycle.
- Address increment takes effect the cycle after the strobe.
- busy follows synchronized cs (same latency as edge detect); frame_done is high in the cycle busy first reads low.
- Minimum SCK high and low time: 2 clk cycles each; violations are out of spec, no recovery required beyond next cs fall.
- Mid-operation reset: outputs return to reset values on the next clk edge; current frame is lost, the block resynchronizes on the next cs rise.

## Test plan
- Frame bytes 0x01,0x20,0xAA,0x55,0x0F -> three strobes: (0x0120,0xAA),(0x0121,0x55),(0x0122,0x0F); bytes_written=3; one frame_done.
- Address 0xFFFF, data 0x11,0x22 -> writes (0xFFFF,0x11),(0x0000,0x22).
- Address 0x0010, data 0xC3 then 5 more bits then cs fall -> exactly one write (0x0010,0xC3); bytes_written=1; no further strobe.
- cs fall after 12 bits (address incomplete) -> zero writes, frame_done pulse, state IDLE; next full frame writes correctly.
- resetn low for one cycle during 2nd data byte -> all outputs zero next cycle, no strobe for that byte; following frame 0x00,0x05,0x7E -> write (0x0005,0x7E).
- SCK at clk/4 with random data for 64 bytes -> every byte and address matches scoreboard, strobe latency constant.
